grid_mem_arbiter: RTL and testbench

- Shares one single-port 256x2 grid memory between two requesters:
  - the game control FSM (read/write, high priority);
  - the display grid reader (read-only, low priority, starvation-protected).
- Issues at most one memory access per cycle and routes read data back to the requester that issued it.
- Supports an FSM lock for read-modify-write sequences (read cell, check, write HIT/MISS).
- Sits between main control / display logic and each grid RAM; one instance per grid (own and enemy).

---
 rtl/grid_mem_arbiter.sv | 79 +++++++
 tb/tb_grid_mem_arbiter.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/grid_mem_arbiter.sv
// grid_mem_arbiter: shares one grid RAM between the game FSM (priority, lockable) and the display reader.
module grid_mem_arbiter #(
    parameter int MEM_LATENCY  = 1,
    parameter int STARVE_LIMIT = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       fsm_req,
    input  logic       fsm_w_nr,
    input  logic [7:0] fsm_addr,
    input  logic [1:0] fsm_wdata,
    input  logic       fsm_lock,
    output logic       fsm_gnt,
    output logic [1:0] fsm_rdata,
    output logic       fsm_rvalid,
    input  logic       disp_req,
    input  logic [7:0] disp_addr,
    output logic       disp_gnt,
    output logic [1:0] disp_rdata,
    output logic       disp_rvalid,
    output logic       mem_en,
    output logic       mem_w_nr,
    output logic [7:0] mem_addr,
    output logic [1:0] mem_wdata,
    input  logic [1:0] mem_rdata
);
    logic [3:0]           starve_ctr;
    logic                 starved;
    logic [MEM_LATENCY:0] tag_rd;
    logic [MEM_LATENCY:0] tag_disp;

    always_comb begin
        starved  = starve_ctr >= 4'(STARVE_LIMIT);
        fsm_gnt  = fsm_req & (fsm_lock | ~(starved & disp_req));
        disp_gnt = disp_req & ~fsm_lock & (starved | ~fsm_req);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_ctr <= '0;
            mem_en     <= 1'b0;
            mem_w_nr   <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            starve_ctr <= (!disp_req || disp_gnt) ? 4'd0 : (starve_ctr == 4'd15 ? 4'd15 : starve_ctr + 4'd1);
            mem_en     <= fsm_gnt | disp_gnt;
            mem_w_nr   <= fsm_gnt & fsm_w_nr;
            if (fsm_gnt) begin
                mem_addr  <= fsm_addr;
                mem_wdata <= fsm_wdata;
            end else if (disp_gnt) begin
                mem_addr  <= disp_addr;
                mem_wdata <= 2'b00;
            end
        end
    end

    // Tag stage k belongs to the grant issued k+1 cycles ago; the last stage lines up with mem_rdata.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_rd      <= '0;
            tag_disp    <= '0;
            fsm_rvalid  <= 1'b0;
            disp_rvalid <= 1'b0;
            fsm_rdata   <= '0;
            disp_rdata  <= '0;
        end else begin
            tag_rd      <= {tag_rd[MEM_LATENCY-1:0], (fsm_gnt & ~fsm_w_nr) | disp_gnt};
            tag_disp    <= {tag_disp[MEM_LATENCY-1:0], disp_gnt};
            fsm_rvalid  <= tag_rd[MEM_LATENCY] & ~tag_disp[MEM_LATENCY];
            disp_rvalid <= tag_rd[MEM_LATENCY] & tag_disp[MEM_LATENCY];
            if (tag_rd[MEM_LATENCY] && !tag_disp[MEM_LATENCY])
                fsm_rdata <= mem_rdata;
            if (tag_rd[MEM_LATENCY] && tag_disp[MEM_LATENCY])
                disp_rdata <= mem_rdata;
        end
    end
endmodule

// File: tb/tb_grid_mem_arbiter.sv
// tb_grid_mem_arbiter: directed checks of arbitration, starvation, lock and read routing.
module tb_grid_mem_arbiter;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       fsm_req = 1'b0, fsm_w_nr = 1'b0, fsm_lock = 1'b0;
    logic [7:0] fsm_addr = '0, disp_addr = '0;
    logic [1:0] fsm_wdata = '0;
    logic       disp_req = 1'b0;
    logic       fsm_gnt, fsm_rvalid, disp_gnt, disp_rvalid;
    logic [1:0] fsm_rdata, disp_rdata, mem_wdata;
    logic       mem_en, mem_w_nr;
    logic [7:0] mem_addr;
    logic [1:0] mem_rdata;
    logic [1:0] mem [256];
    int         tests = 0;
    int         fails = 0;

    grid_mem_arbiter dut (
        .clk(clk), .rst(rst),
        .fsm_req(fsm_req), .fsm_w_nr(fsm_w_nr), .fsm_addr(fsm_addr), .fsm_wdata(fsm_wdata),
        .fsm_lock(fsm_lock), .fsm_gnt(fsm_gnt), .fsm_rdata(fsm_rdata), .fsm_rvalid(fsm_rvalid),
        .disp_req(disp_req), .disp_addr(disp_addr), .disp_gnt(disp_gnt),
        .disp_rdata(disp_rdata), .disp_rvalid(disp_rvalid),
        .mem_en(mem_en), .mem_w_nr(mem_w_nr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // One-cycle-latency RAM model
    always @(posedge clk) begin
        if (mem_en && mem_w_nr) mem[mem_addr] <= mem_wdata;
        if (mem_en && !mem_w_nr) mem_rdata <= mem[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 2'b00;
        mem[8'h23] = 2'b01;
        mem[8'h10] = 2'b11;
        mem[8'h11] = 2'b01;
        mem[8'h12] = 2'b10;
        mem_rdata = 2'b00;
        cyc(); cyc();
        check("rst_mem_en", mem_en, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_fsm_rvalid", fsm_rvalid, 0);
        check("rst_disp_rvalid", disp_rvalid, 0);
        rst = 1'b0;
        cyc();
        // FSM read 0x23
        fsm_req = 1; fsm_w_nr = 0; fsm_addr = 8'h23;
        #1 check("rd_fsm_gnt", fsm_gnt, 1);
        check("rd_disp_gnt", disp_gnt, 0);
        cyc(); fsm_req = 0;
        check("rd_mem_en", mem_en, 1);
        check("rd_mem_addr", mem_addr, 8'h23);
        check("rd_mem_w_nr", mem_w_nr, 0);
        cyc();
        check("rd_early_rvalid", fsm_rvalid, 0);
        cyc();
        check("rd_fsm_rvalid", fsm_rvalid, 1);
        check("rd_fsm_rdata", fsm_rdata, 2'b01);
        check("rd_disp_rvalid", disp_rvalid, 0);
        cyc();
        check("rd_pulse_end", fsm_rvalid, 0);
        check("rd_rdata_hold", fsm_rdata, 2'b01);
        // FSM write 0x45 <= 10
        fsm_req = 1; fsm_w_nr = 1; fsm_addr = 8'h45; fsm_wdata = 2'b10;
        #1 check("wr_fsm_gnt", fsm_gnt, 1);
        cyc(); fsm_req = 0; fsm_w_nr = 0;
        check("wr_mem_en", mem_en, 1);
        check("wr_mem_w_nr", mem_w_nr, 1);
        check("wr_mem_wdata", mem_wdata, 2'b10);
        cyc();
        check("wr_mem_w_nr_drop", mem_w_nr, 0);
        check("wr_mem_en_drop", mem_en, 0);
        check("wr_wdata_hold", mem_wdata, 2'b10);
        check("wr_no_rvalid_a", fsm_rvalid, 0);
        cyc();
        check("wr_no_rvalid_b", fsm_rvalid, 0);
        // Display read-back of 0x45
        disp_req = 1; disp_addr = 8'h45;
        #1 check("dr_disp_gnt", disp_gnt, 1);
        cyc(); disp_req = 0;
        check("dr_mem_wdata", mem_wdata, 0);
        cyc(); cyc();
        check("dr_disp_rvalid", disp_rvalid, 1);
        check("dr_disp_rdata", disp_rdata, 2'b10);
        check("dr_fsm_rvalid", fsm_rvalid, 0);
        cyc();
        // Starvation: display wins once on cycle 8
        fsm_req = 1; fsm_addr = 8'h30; disp_req = 1; disp_addr = 8'h31;
        for (int k = 0; k < 11; k++) begin
            #1 check($sformatf("starve_fsm_gnt_%0d", k), fsm_gnt, k != 8);
            check($sformatf("starve_disp_gnt_%0d", k), disp_gnt, k == 8);
            cyc();
        end
        fsm_req = 0; disp_req = 0;
        cyc(); cyc(); cyc(); cyc();
        // Lock blocks the display for 20 cycles
        fsm_lock = 1; disp_req = 1; disp_addr = 8'h11;
        for (int k = 0; k < 20; k++) begin
            fsm_req = (k >= 18);
            #1 check($sformatf("lock_disp_gnt_%0d", k), disp_gnt, 0);
            check($sformatf("lock_fsm_gnt_%0d", k), fsm_gnt, k >= 18);
            cyc();
        end
        check("lock_ctr_sat", dut.starve_ctr, 15);
        fsm_lock = 0; fsm_req = 1;
        #1 check("unlock_disp_gnt", disp_gnt, 1);
        check("unlock_fsm_gnt", fsm_gnt, 0);
        cyc(); fsm_req = 0; disp_req = 0;
        cyc(); cyc(); cyc(); cyc();
        // Alternating back-to-back reads
        fsm_req = 1; fsm_addr = 8'h10;
        #1 check("alt_gnt0", fsm_gnt, 1);
        cyc(); fsm_req = 0; disp_req = 1; disp_addr = 8'h11;
        #1 check("alt_gnt1", disp_gnt, 1);
        cyc(); disp_req = 0; fsm_req = 1; fsm_addr = 8'h12;
        #1 check("alt_gnt2", fsm_gnt, 1);
        cyc(); fsm_req = 0;
        check("alt_c3_fsm_rvalid", fsm_rvalid, 1);
        check("alt_c3_fsm_rdata", fsm_rdata, 2'b11);
        check("alt_c3_disp_rvalid", disp_rvalid, 0);
        cyc();
        check("alt_c4_disp_rvalid", disp_rvalid, 1);
        check("alt_c4_disp_rdata", disp_rdata, 2'b01);
        check("alt_c4_fsm_rvalid", fsm_rvalid, 0);
        cyc();
        check("alt_c5_fsm_rvalid", fsm_rvalid, 1);
        check("alt_c5_fsm_rdata", fsm_rdata, 2'b10);
        cyc();
        // Reset right after a read grant drops the read
        fsm_req = 1; fsm_addr = 8'h23;
        #1 check("mr_fsm_gnt", fsm_gnt, 1);
        cyc(); fsm_req = 0; rst = 1;
        cyc(); rst = 0;
        check("mr_mem_en", mem_en, 0);
        check("mr_mem_addr", mem_addr, 0);
        check("mr_fsm_rdata", fsm_rdata, 0);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("mr_no_rvalid_%0d", k), fsm_rvalid, 0);
            cyc();
        end
        fsm_req = 1; fsm_addr = 8'h23;
        #1 check("post_fsm_gnt", fsm_gnt, 1);
        cyc(); fsm_req = 0;
        cyc(); cyc();
        check("post_fsm_rvalid", fsm_rvalid, 1);
        check("post_fsm_rdata", fsm_rdata, 2'b01);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
